// File: rtl/fpu_seq_divider.sv
// Sequential radix-2 restoring divider for signed/unsigned integers.
// One quotient bit per cycle, sign fix-up afterwards, valid/ready handshakes on both sides.
module fpu_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             isSigned,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMP, FIX, DONE} stateE;

  stateE state, stateNext;

  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divMag;
  logic             negQuo;
  logic             negRem;
  logic             ovfPend;

  logic [WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0] dvsMag;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trialDiff;
  logic             stepFits;
  logic [WIDTH-1:0] stepRem;
  logic             mostNegByMinusOne;

  // The magnitude of the most-negative value wraps to itself, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  assign dvdMag = (isSigned && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvsMag = (isSigned && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign mostNegByMinusOne = isSigned && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                             && (divisor == {WIDTH{1'b1}});

  // A shifted-out bit in remShift[WIDTH] guarantees the trial fits; otherwise
  // the borrow in trialDiff[WIDTH] says the subtraction went negative.
  assign remShift  = {remReg, quoReg[WIDTH-1]};
  assign trialDiff = remShift - {1'b0, divMag};
  assign stepFits  = remShift[WIDTH] | ~trialDiff[WIDTH];
  assign stepRem   = stepFits ? trialDiff[WIDTH-1:0] : remShift[WIDTH-1:0];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
    stateNext = state;
    case (state)
      IDLE: if (inValid) stateNext = (divisor == '0) ? DONE : COMP;
      COMP: if (counter == CW'(1)) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: if (outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    inReady  = (state == IDLE);
    outValid = (state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      counter   <= '0;
      remReg    <= '0;
      quoReg    <= '0;
      divMag    <= '0;
      negQuo    <= 1'b0;
      negRem    <= 1'b0;
      ovfPend   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              divByZero <= 1'b1;
              overflow  <= 1'b0;
              counter   <= '0;
            end else begin
              remReg  <= '0;
              quoReg  <= dvdMag;
              divMag  <= dvsMag;
              negQuo  <= isSigned && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              negRem  <= isSigned && dividend[WIDTH-1];
              ovfPend <= mostNegByMinusOne;
              counter <= CW'(WIDTH);
            end
          end
        end
        COMP: begin
          remReg  <= stepRem;
          quoReg  <= {quoReg[WIDTH-2:0], stepFits};
          counter <= counter - CW'(1);
        end
        FIX: begin
          quotient  <= negQuo ? -quoReg : quoReg;
          remainder <= negRem ? -remReg : remReg;
          divByZero <= 1'b0;
          overflow  <= ovfPend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_divider.sv
// Directed bench for fpu_seq_divider at WIDTH=16: hand-computed quotients,
// remainders, flags, latencies, backpressure and mid-operation reset.
module tb_fpu_seq_divider;

  logic        clock;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        isSigned;
  logic        outValid;
  logic        outReady;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        divByZero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  fpu_seq_divider #(.WIDTH(16)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .inValid   (inValid),
    .inReady   (inReady),
    .dividend  (dividend),
    .divisor   (divisor),
    .isSigned  (isSigned),
    .outValid  (outValid),
    .outReady  (outReady),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation from IDLE, counts edges (accept edge included) until
  // outValid, checks the result, and optionally hands it off back to IDLE.
  task automatic runOp(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                       input logic sgn, input int expLat, input logic [15:0] expQ,
                       input logic [15:0] expR, input logic expDbz, input logic expOvf,
                       input bit handOff);
    int edges = 0;
    dividend = dvd;
    divisor  = dvs;
    isSigned = sgn;
    inValid  = 1'b1;
    do begin
      @(posedge clock);
      #1;
      inValid = 1'b0;
      edges++;
    end while (!outValid && edges < 40);
    check({tag, " latency"},   64'(edges),     64'(expLat));
    check({tag, " quotient"},  64'(quotient),  64'(expQ));
    check({tag, " remainder"}, 64'(remainder), 64'(expR));
    check({tag, " divByZero"}, 64'(divByZero), 64'(expDbz));
    check({tag, " overflow"},  64'(overflow),  64'(expOvf));
    check({tag, " inReady in DONE"}, 64'(inReady), 64'd0);
    if (handOff) begin
      outReady = 1'b1;
      @(posedge clock);
      #1;
      outReady = 1'b0;
      check({tag, " back to IDLE"}, 64'(inReady), 64'd1);
      check({tag, " outValid dropped"}, 64'(outValid), 64'd0);
    end
  endtask

  initial begin
    resetN   = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    dividend = '0;
    divisor  = '0;
    isSigned = 1'b0;

    #12;
    check("reset inReady",   64'(inReady),   64'd1);
    check("reset outValid",  64'(outValid),  64'd0);
    check("reset quotient",  64'(quotient),  64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset divByZero", 64'(divByZero), 64'd0);
    check("reset overflow",  64'(overflow),  64'd0);
    resetN = 1'b1;

    // First edge after reset release accepts the operation.
    runOp("u 100/7",        16'd100,  16'd7,    1'b0, 18, 16'd14,   16'd2,    1'b0, 1'b0, 1'b1);
    runOp("s -7/2",         16'hFFF9, 16'h0002, 1'b1, 18, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    runOp("s 7/-2",         16'h0007, 16'hFFFE, 1'b1, 18, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 1'b1);
    runOp("s -100/-7",      16'hFF9C, 16'hFFF9, 1'b1, 18, 16'd14,   16'hFFFE, 1'b0, 1'b0, 1'b1);
    runOp("u 1234/0",       16'h1234, 16'h0000, 1'b0, 1,  16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b1);
    runOp("s 1234/0",       16'h1234, 16'h0000, 1'b1, 1,  16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b1);
    runOp("s 8000/FFFF",    16'h8000, 16'hFFFF, 1'b1, 18, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1);
    runOp("u 8000/FFFF",    16'h8000, 16'hFFFF, 1'b0, 18, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1);

    // Backpressure: 1000/33 = 30 r 10 held while new requests are offered.
    runOp("u 1000/33",      16'd1000, 16'd33,   1'b0, 18, 16'd30,   16'd10,   1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dividend = 16'd5;
      divisor  = 16'd1;
      isSigned = 1'b0;
      inValid  = 1'b1;
      @(posedge clock);
      #1;
      check("hold quotient",  64'(quotient),  64'd30);
      check("hold remainder", 64'(remainder), 64'd10);
      check("hold outValid",  64'(outValid),  64'd1);
      check("hold inReady",   64'(inReady),   64'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    check("release inReady",  64'(inReady),  64'd1);
    check("release outValid", 64'(outValid), 64'd0);
    check("idle keeps quotient",  64'(quotient),  64'd30);
    check("idle keeps remainder", 64'(remainder), 64'd10);
    repeat (3) begin
      @(posedge clock);
      #1;
      check("no stray op outValid", 64'(outValid), 64'd0);
      check("no stray op inReady",  64'(inReady),  64'd1);
    end

    // Reset in the middle of COMP (after 8 steps the counter is 8).
    dividend = 16'd50000;
    divisor  = 16'd3;
    isSigned = 1'b0;
    inValid  = 1'b1;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    check("comp inReady", 64'(inReady), 64'd0);
    repeat (8) @(posedge clock);
    #1;
    resetN = 1'b0;
    #1;
    check("midreset inReady",   64'(inReady),   64'd1);
    check("midreset outValid",  64'(outValid),  64'd0);
    check("midreset quotient",  64'(quotient),  64'd0);
    check("midreset remainder", 64'(remainder), 64'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    check("post reset outValid", 64'(outValid), 64'd0);

    runOp("u 65535/1",      16'hFFFF, 16'h0001, 1'b0, 18, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
